apb_cmd_master: RTL and testbench



---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_wait_timer.sv | 34 +++
 rtl/apb_cmd_master.sv | 155 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the a-side APB command master.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_ADDR_WD     = 8;
  localparam int unsigned APB_DATA_WD     = 6;
  localparam int unsigned APB_STRB_WD     = 2;
  localparam int unsigned APB_PROT_WD     = 4;
  localparam int unsigned APB_TIMEOUT_CYC = 64;
  localparam int unsigned APB_CNT_WD      = 16;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 32'd1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait counter; o_hit pulses on the cycle whose increment reaches THRESH.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned THRESH = APB_TIMEOUT_CYC
) (
  input  logic a_pclk,
  input  logic a_prst_n,
  input  logic i_start,
  input  logic i_inc,
  output logic o_hit
);

  localparam int unsigned W = cnt_width(THRESH);
  localparam logic [W-1:0] LIM = W'(THRESH);

  logic [W-1:0] r_cnt;

  // Cleared on ACCESS entry, counts stalled ACCESS cycles, sticks at the limit.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_hit = i_inc && (r_cnt == (LIM - W'(1)));

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to APB SETUP/ACCESS sequencer with a valid/ready response channel.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WD     = APB_ADDR_WD,
  parameter int unsigned DATA_WD     = APB_DATA_WD,
  parameter int unsigned STRB_WD     = APB_STRB_WD,
  parameter int unsigned PROT_WD     = APB_PROT_WD,
  parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC,
  parameter int unsigned CNT_WD      = APB_CNT_WD
) (
  input  logic               a_pclk,
  input  logic               a_prst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  input  logic [STRB_WD-1:0] cmd_strb,
  input  logic [PROT_WD-1:0] cmd_prot,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic               rsp_write,
  output logic               a_psel,
  output logic               a_penable,
  output logic               a_pwrite,
  output logic [ADDR_WD-1:0] a_paddr,
  output logic [DATA_WD-1:0] a_pwdata,
  output logic [STRB_WD-1:0] a_pstrb,
  output logic [PROT_WD-1:0] a_pprot,
  input  logic [DATA_WD-1:0] a_prdata,
  input  logic               a_pready,
  output logic               busy,
  output logic               timeout_err,
  input  logic               clr_err,
  output logic [CNT_WD-1:0]  txn_cnt
);

  apb_state_e r_state;
  apb_state_e w_state_nxt;
  logic       w_accept;
  logic       w_done;
  logic       w_hit;

  // Held low while in reset so nothing upstream sees a phantom accept.
  assign cmd_ready = a_prst_n && (r_state == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign busy      = (r_state != ST_IDLE);

  // Next-state decode; accept and completion strobes derived here.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (a_pready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // APB request outputs; address/data hold after completion, strobes drop.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      a_psel    <= 1'b0;
      a_penable <= 1'b0;
      a_pwrite  <= 1'b0;
      a_paddr   <= '0;
      a_pwdata  <= '0;
      a_pstrb   <= '0;
      a_pprot   <= '0;
    end else if (w_accept) begin
      a_psel    <= 1'b1;
      a_penable <= 1'b0;
      a_pwrite  <= cmd_write;
      a_paddr   <= cmd_addr;
      a_pwdata  <= cmd_wdata;
      a_pstrb   <= cmd_write ? cmd_strb : '0;
      a_pprot   <= cmd_prot;
    end else if (r_state == ST_SETUP) begin
      a_penable <= 1'b1;
    end else if (w_done) begin
      a_psel    <= 1'b0;
      a_penable <= 1'b0;
      a_pstrb   <= '0;
    end
  end

  // Response channel and completed-transfer counter.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      txn_cnt   <= '0;
    end else if (w_done) begin
      rsp_valid <= 1'b1;
      rsp_write <= a_pwrite;
      rsp_rdata <= a_pwrite ? '0 : a_prdata;
      txn_cnt   <= txn_cnt + CNT_WD'(1);
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Sticky timeout flag; a hit on the same edge as a clear keeps it set.
  always_ff @(posedge a_pclk or negedge a_prst_n) begin
    if (!a_prst_n) begin
      timeout_err <= 1'b0;
    end else if (w_hit) begin
      timeout_err <= 1'b1;
    end else if (clr_err) begin
      timeout_err <= 1'b0;
    end
  end

  apb_wait_timer #(
    .THRESH (TIMEOUT_CYC)
  ) u_wait_timer (
    .a_pclk   (a_pclk),
    .a_prst_n (a_prst_n),
    .i_start  (r_state == ST_SETUP),
    .i_inc    ((r_state == ST_ACCESS) && !a_pready),
    .o_hit    (w_hit)
  );

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: inline APB checks plus a response scoreboard.
module tb_apb_cmd_master;

  localparam int AW = 8;
  localparam int DW = 6;
  localparam int SW = 2;
  localparam int PW = 4;
  localparam int TO = 4;
  localparam int CW = 16;

  logic          a_pclk;
  logic          a_prst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [PW-1:0] cmd_prot;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_write;
  logic          a_psel;
  logic          a_penable;
  logic          a_pwrite;
  logic [AW-1:0] a_paddr;
  logic [DW-1:0] a_pwdata;
  logic [SW-1:0] a_pstrb;
  logic [PW-1:0] a_pprot;
  logic [DW-1:0] a_prdata;
  logic          a_pready;
  logic          busy;
  logic          timeout_err;
  logic          clr_err;
  logic [CW-1:0] txn_cnt;

  int            checks;
  int            errors;
  int            exp_cnt;
  bit            exp_to;
  longint        t_acc;
  longint        t_done;
  longint        t0;
  logic [DW:0]   exp_q[$];

  apb_cmd_master #(
    .ADDR_WD(AW), .DATA_WD(DW), .STRB_WD(SW), .PROT_WD(PW),
    .TIMEOUT_CYC(TO), .CNT_WD(CW)
  ) dut (
    .a_pclk(a_pclk), .a_prst_n(a_prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
    .a_psel(a_psel), .a_penable(a_penable), .a_pwrite(a_pwrite), .a_paddr(a_paddr),
    .a_pwdata(a_pwdata), .a_pstrb(a_pstrb), .a_pprot(a_pprot), .a_prdata(a_prdata),
    .a_pready(a_pready), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err),
    .txn_cnt(txn_cnt)
  );

  initial begin
    a_pclk = 1'b0;
    forever #5 a_pclk = ~a_pclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bus_now();
    return 32'({a_psel, a_penable, a_pwrite, a_paddr, a_pwdata, a_pstrb, a_pprot});
  endfunction

  function automatic logic [31:0] bus_exp(input logic sel, input logic en, input logic wr,
                                          input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                                          input logic [SW-1:0] st, input logic [PW-1:0] pr);
    return 32'({sel, en, wr, ad, wd, st, pr});
  endfunction

  // Scoreboard monitor: a response is consumed on the next edge when valid&ready.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge a_pclk);
      #2;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_write", 32'(rsp_write), 32'(e[DW]));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e[DW-1:0]));
        end
      end
    end
  end

  // Issue one command (caller is at a negedge) and play a slave with 'waits' wait states.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input logic [PW-1:0] pr, input int waits,
                        input logic [DW-1:0] rd, input bit clr_hit);
    logic [SW-1:0] est;
    int n;
    est = wr ? st : 2'b00;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = ad; cmd_wdata = wd;
    cmd_strb = st; cmd_prot = pr;
    n = 0;
    #1;
    while (!cmd_ready && n < 50) begin
      @(negedge a_pclk);
      #1;
      n++;
    end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back({wr, (wr ? 6'h00 : rd)});
    @(posedge a_pclk);
    t_acc = $time;
    #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~ad; cmd_wdata = ~wd;
    cmd_strb = ~st; cmd_prot = ~pr;
    @(negedge a_pclk);
    chk("setup_bus", bus_now(), bus_exp(1'b1, 1'b0, wr, ad, wd, est, pr));
    chk("setup_busy", 32'(busy), 32'd1);
    a_pready = 1'b0;
    a_prdata = rd;
    for (int k = 0; k <= waits; k++) begin
      @(negedge a_pclk);
      chk("access_bus", bus_now(), bus_exp(1'b1, 1'b1, wr, ad, wd, est, pr));
      if (k >= TO) exp_to = 1'b1;
      chk("access_timeout", 32'(timeout_err), 32'(exp_to));
      clr_err  = clr_hit && (k == TO - 1);
      a_pready = (k == waits);
    end
    @(negedge a_pclk);
    clr_err  = 1'b0;
    a_pready = 1'b0;
    t_done   = $time - 5;
    exp_cnt++;
    chk("done_bus", bus_now(), bus_exp(1'b0, 1'b0, wr, ad, wd, 2'b00, pr));
    chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
    chk("done_timeout", 32'(timeout_err), 32'(exp_to));
  endtask

  task automatic clear_err();
    clr_err = 1'b1;
    @(negedge a_pclk);
    clr_err = 1'b0;
    #1;
    exp_to = 1'b0;
    chk("clr_err", 32'(timeout_err), 32'd0);
    @(negedge a_pclk);
  endtask

  initial begin
    checks = 0; errors = 0; exp_cnt = 0; exp_to = 1'b0;
    a_prst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b1;
    a_prdata = '0; a_pready = 1'b0; clr_err = 1'b0;
    @(negedge a_pclk);
    @(negedge a_pclk);
    #1;
    chk("reset_bus", bus_now(), 32'd0);
    chk("reset_ctl", 32'({rsp_valid, rsp_write, rsp_rdata, busy, timeout_err, cmd_ready}), 32'd0);
    chk("reset_txn_cnt", 32'(txn_cnt), 32'd0);
    @(negedge a_pclk);
    a_prst_n = 1'b1;
    @(negedge a_pclk);

    // Single zero-wait write; slave data must not leak into a write response.
    do_cmd(1'b1, 8'h12, 6'h2A, 2'b11, 4'h0, 0, 6'h07, 1'b0);
    chk("write_latency", 32'(t_done - t_acc), 32'd20);

    // Read with 4 wait states; strobes forced to zero, the wait trips the timeout.
    do_cmd(1'b0, 8'h05, 6'h11, 2'b11, 4'h5, 4, 6'h15, 1'b0);

    // Four back-to-back zero-wait writes.
    do_cmd(1'b1, 8'h00, 6'h10, 2'b01, 4'h1, 0, 6'h00, 1'b0);
    t0 = t_acc;
    for (int i = 1; i < 4; i++) begin
      do_cmd(1'b1, 8'(i), 6'(16 + i), 2'b10, 4'h2, 0, 6'h00, 1'b0);
    end
    chk("b2b_cycles", 32'((t_done - t0 + 10) / 10), 32'd12);

    // Response stall blocks the next command.
    @(negedge a_pclk);
    rsp_ready = 1'b0;
    do_cmd(1'b0, 8'h08, 6'h00, 2'b00, 4'h3, 0, 6'h3F, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 6'h01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("stall_psel", 32'(a_psel), 32'd0);
      chk("stall_rsp", 32'({rsp_valid, rsp_write, rsp_rdata}), 32'({1'b1, 1'b0, 6'h3F}));
      @(negedge a_pclk);
    end
    rsp_ready = 1'b1;
    do_cmd(1'b1, 8'h20, 6'h01, 2'b11, 4'h0, 1, 6'h22, 1'b0);
    clear_err();

    // Long wait: timeout with a coincident clear, transfer still completes.
    do_cmd(1'b0, 8'h44, 6'h00, 2'b00, 4'h7, 10, 6'h2C, 1'b1);
    clear_err();

    // Asynchronous reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33; cmd_prot = 4'h0;
    @(posedge a_pclk);
    #1;
    cmd_valid = 1'b0;
    @(negedge a_pclk);
    @(negedge a_pclk);
    @(negedge a_pclk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    a_prst_n = 1'b0;
    #1;
    chk("mid_reset_ctl", 32'({a_psel, a_penable, rsp_valid, busy, cmd_ready}), 32'd0);
    chk("mid_reset_txn_cnt", 32'(txn_cnt), 32'd0);
    exp_cnt = 0;
    exp_to  = 1'b0;
    @(negedge a_pclk);
    a_prst_n = 1'b1;
    @(negedge a_pclk);
    do_cmd(1'b1, 8'h7E, 6'h33, 2'b01, 4'h9, 2, 6'h00, 1'b0);

    @(negedge a_pclk);
    @(negedge a_pclk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
